// File: rtl/noc_out_port_arbiter.sv
// ============================================================================
// Module   : noc_out_port_arbiter
// Brief    : Two-requester round-robin arbiter feeding one registered output
//            stage. Optional macro ARB_STATS_EN adds grant and stall counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_out_port_arbiter #(
    parameter int DATA_WIDTH = 34,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  i_sclk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic                  i_data_valid0,
    output logic                  o_data_ready0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    input  logic                  i_data_valid1,
    output logic                  o_data_ready1,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
`ifdef ARB_STATS_EN
    output logic [15:0]           o_grant_cnt0,
    output logic [15:0]           o_grant_cnt1,
    output logic [15:0]           o_stall_cnt,
`endif
    output logic                  o_grant
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_lp;
    logic                  r_grant;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  w_load_en;
    logic                  w_gnt;
    logic                  w_xfer;

    // The destination field must fit inside a flit.
    generate
        if (ADDR_WIDTH > DATA_WIDTH) begin : g_param_check
            $error("ADDR_WIDTH must not exceed DATA_WIDTH");
        end
    endgenerate

    assign w_load_en = (r_state == S_EMPTY) | i_data_ready;

    // Under contention the requester that did not win last time goes first.
    assign w_gnt = (i_data_valid0 & i_data_valid1) ? ~r_lp : i_data_valid1;

    assign o_data_ready0 = i_reset & w_load_en & i_data_valid0 & ~w_gnt;
    assign o_data_ready1 = i_reset & w_load_en & i_data_valid1 &  w_gnt;
    assign w_xfer        = o_data_ready0 | o_data_ready1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_xfer)                      w_state_nxt = S_FULL;
            S_FULL:  if (i_data_ready && !w_xfer)     w_state_nxt = S_EMPTY;
            default:                                  w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge i_sclk) begin
        if (!i_reset) begin
            r_state <= S_EMPTY;
            r_data  <= '0;
            r_grant <= 1'b0;
            r_lp    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_data  <= w_gnt ? i_data1 : i_data0;
                r_grant <= w_gnt;
                r_lp    <= w_gnt;
            end
        end
    end

    assign o_data       = r_data;
    assign o_data_valid = (r_state == S_FULL);
    assign o_grant      = r_grant;

`ifdef ARB_STATS_EN
    logic [15:0] r_grant_cnt0;
    logic [15:0] r_grant_cnt1;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_sclk) begin
        if (!i_reset) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (o_data_ready0)                  r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
            if (o_data_ready1)                  r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
            if (o_data_valid && !i_data_ready)  r_stall_cnt  <= r_stall_cnt + 16'd1;
        end
    end

    assign o_grant_cnt0 = r_grant_cnt0;
    assign o_grant_cnt1 = r_grant_cnt1;
    assign o_stall_cnt  = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_out_port_arbiter.sv
// ============================================================================
// Module   : tb_noc_out_port_arbiter
// Brief    : Self-checking bench: directed scenarios plus random traffic
//            against a behavioural model of the arbiter and output stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_out_port_arbiter;

    localparam int DW = 34;

    logic          clk = 1'b0;
    logic          i_reset = 1'b0;
    logic [DW-1:0] i_data0 = '0;
    logic [DW-1:0] i_data1 = '0;
    logic          i_data_valid0 = 1'b0;
    logic          i_data_valid1 = 1'b0;
    logic          i_data_ready = 1'b0;
    logic          o_data_ready0;
    logic          o_data_ready1;
    logic [DW-1:0] o_data;
    logic          o_data_valid;
    logic          o_grant;
`ifdef ARB_STATS_EN
    logic [15:0]   o_grant_cnt0;
    logic [15:0]   o_grant_cnt1;
    logic [15:0]   o_stall_cnt;
`endif

    noc_out_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(2)) u_dut (
        .i_sclk        (clk),
        .i_reset       (i_reset),
        .i_data0       (i_data0),
        .i_data_valid0 (i_data_valid0),
        .o_data_ready0 (o_data_ready0),
        .i_data1       (i_data1),
        .i_data_valid1 (i_data_valid1),
        .o_data_ready1 (o_data_ready1),
        .o_data        (o_data),
        .o_data_valid  (o_data_valid),
        .i_data_ready  (i_data_ready),
`ifdef ARB_STATS_EN
        .o_grant_cnt0  (o_grant_cnt0),
        .o_grant_cnt1  (o_grant_cnt1),
        .o_stall_cnt   (o_stall_cnt),
`endif
        .o_grant       (o_grant)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of what the output link should show.
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_grant;
    logic          m_last;
    int            m_cnt0, m_cnt1, m_stall;
    logic          last_r0, last_r1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_data = '0; m_grant = 1'b0; m_last = 1'b1;
        m_cnt0 = 0; m_cnt1 = 0; m_stall = 0;
    endtask

    // One clock: apply inputs, check combinational and registered outputs, advance model.
    task automatic cyc(input logic rn, input logic v0, input logic v1, input logic rdy,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        logic room, who, e0, e1;
        i_reset = rn; i_data_valid0 = v0; i_data_valid1 = v1;
        i_data_ready = rdy; i_data0 = d0; i_data1 = d1;
        #3;
        room = !m_valid || rdy;
        who  = (v0 && v1) ? !m_last : v1;
        e0   = rn && room && v0 && (who == 1'b0);
        e1   = rn && room && v1 && (who == 1'b1);
        check_eq("ready0", 64'(o_data_ready0), 64'(e0));
        check_eq("ready1", 64'(o_data_ready1), 64'(e1));
        check_eq("valid",  64'(o_data_valid),  64'(m_valid));
        check_eq("data",   64'(o_data),        64'(m_data));
        check_eq("grant",  64'(o_grant),       64'(m_grant));
`ifdef ARB_STATS_EN
        check_eq("cnt0",   64'(o_grant_cnt0),  64'(m_cnt0 % 65536));
        check_eq("cnt1",   64'(o_grant_cnt1),  64'(m_cnt1 % 65536));
        check_eq("stall",  64'(o_stall_cnt),   64'(m_stall % 65536));
`endif
        last_r0 = o_data_ready0;
        last_r1 = o_data_ready1;
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            if (m_valid && !rdy) m_stall++;
            if (e0 || e1) begin
                m_data  = e1 ? d1 : d0;
                m_grant = e1;
                m_last  = e1;
                m_valid = 1'b1;
                if (e1) m_cnt1++; else m_cnt0++;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom, $urandom});
    endfunction

    initial begin
        logic [DW-1:0] hold;
        logic [5:0]    gseq;
        int            h0, h1;

        // Initial reset: two edges with reset low before anything is checked.
        i_reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        model_reset();

        // Readys stay low during reset even with requests pending.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, rnd(), rnd());
        check_eq("rst_rdy0", 64'(last_r0), 64'd0);
        check_eq("rst_rdy1", 64'(last_r1), 64'd0);

        // Idle after reset.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, rnd(), rnd());
        check_eq("idle_valid", 64'(o_data_valid), 64'd0);
        check_eq("idle_data",  64'(o_data),       64'd0);

        // Single requester.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 34'h0DEADBEEF, rnd());
        check_eq("single_rdy0",  64'(last_r0),      64'd1);
        check_eq("single_data",  64'(o_data),       64'h0DEADBEEF);
        check_eq("single_valid", 64'(o_data_valid), 64'd1);
        check_eq("single_grant", 64'(o_grant),      64'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, rnd(), rnd());
        check_eq("single_drain", 64'(o_data_valid), 64'd0);

        // Contention from a fresh reset: strict alternation starting with 0.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, rnd(), rnd());
        h0 = 0; h1 = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b1, rnd(), rnd());
            gseq[i] = o_grant;
            h0 += int'(last_r0);
            h1 += int'(last_r1);
        end
        check_eq("cont_seq", 64'(gseq), 64'b101010);
        check_eq("cont_h0",  64'(h0),   64'd3);
        check_eq("cont_h1",  64'(h1),   64'd3);
`ifdef ARB_STATS_EN
        check_eq("stat_cnt0", 64'(o_grant_cnt0), 64'd3);
        check_eq("stat_cnt1", 64'(o_grant_cnt1), 64'd3);
`endif

        // Backpressure while holding requester 1's flit.
        check_eq("bp_grant", 64'(o_grant), 64'd1);
        hold = o_data;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_STATS_EN
            if (i == 3) check_eq("stat_stall", 64'(o_stall_cnt), 64'd3);
`endif
            cyc(1'b1, 1'b1, 1'b1, 1'b0, rnd(), rnd());
            check_eq("bp_rdy",  64'(last_r0 | last_r1), 64'd0);
            check_eq("bp_hold", 64'(o_data),            64'(hold));
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b1, rnd(), rnd());
        check_eq("bp_rel_rdy0",  64'(last_r0),      64'd1);
        check_eq("bp_rel_grant", 64'(o_grant),      64'd0);
        check_eq("bp_rel_valid", 64'(o_data_valid), 64'd1);

        // Mid-operation reset drops the held flit.
        check_eq("mr_pre_valid", 64'(o_data_valid), 64'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, rnd(), rnd());
        check_eq("mr_valid", 64'(o_data_valid), 64'd0);
        check_eq("mr_data",  64'(o_data),       64'd0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, rnd(), rnd());
        check_eq("mr_first0", 64'(last_r0), 64'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) != 0), rnd(), rnd());
        end

`ifdef ARB_STATS_EN
        // Grant counter wrap.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, rnd(), rnd());
        for (int i = 0; i < 65535; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, rnd(), rnd());
        check_eq("wrap_full", 64'(o_grant_cnt0), 64'hFFFF);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, rnd(), rnd());
        check_eq("wrap_zero", 64'(o_grant_cnt0), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
